// File: rtl/sprite_rom_arbiter.sv
// Single-port sprite ROM arbiter with an in-order tag pipeline for read returns.
// Define SPRITE_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module sprite_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 24,
    parameter int ROM_LAT = 2
) (
    input  logic                      VGA_Clk,
    input  logic                      Reset,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    output logic [N_REQ-1:0]          gnt,
    output logic                      rom_rd,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [N_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]  win;
    logic              any_req;
    logic              grant_ok;
    logic [ADDR_W-1:0] win_addr;

    logic [ROM_LAT-1:0] tag_v;
    logic [IDX_W-1:0]   tag_i [ROM_LAT];

`ifdef SPRITE_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            int j;
            j = (int'(ptr) + k) % N_REQ;
            if (!any_req && req[j]) begin
                any_req = 1'b1;
                win     = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge VGA_Clk or posedge Reset) begin
        if (Reset) begin
            ptr <= IDX_W'(N_REQ - 1);
        end else if (grant_ok) begin
            ptr <= win;
        end
    end
`else
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req = 1'b1;
                win     = IDX_W'(i);
            end
        end
    end
`endif

    assign grant_ok = enable & ~Reset & any_req;
    assign gnt      = grant_ok ? (N_REQ'(1) << win) : '0;

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                win_addr = addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Tags ride alongside the ROM access; rd_valid is one more register so it
    // lines up with rom_data arriving ROM_LAT clocks after rom_rd.
    always_ff @(posedge VGA_Clk or posedge Reset) begin
        if (Reset) begin
            rom_rd   <= 1'b0;
            rom_addr <= '0;
            tag_v    <= '0;
            rd_valid <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                tag_i[k] <= '0;
            end
        end else begin
            rom_rd   <= grant_ok;
            if (grant_ok) begin
                rom_addr <= win_addr;
            end
            tag_v[0] <= grant_ok;
            tag_i[0] <= win;
            for (int k = 1; k < ROM_LAT; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_i[k] <= tag_i[k-1];
            end
            rd_valid <= tag_v[ROM_LAT-1] ? (N_REQ'(1) << tag_i[ROM_LAT-1]) : '0;
        end
    end

    assign rd_data = (|rd_valid) ? rom_data : '0;
    assign busy    = rom_rd | (|tag_v) | (|rd_valid);

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one single-port sprite/background pixel ROM among up to four VGA renderers (start, win, lose and game screens). It sits between the renderers and the ROM and accepts at most one read per clock. A registered tag pipeline returns each read word to the requester that issued it, in order, with fixed latency. It lets every screen renderer run from one ROM and frees block RAM.

## Interface
Parameters:
- N_REQ, 4: number of requesters, legal range 2..4.
- ADDR_W, 16: ROM word address width.
- DATA_W, 24: ROM word width ({R,G,B}, 8 bits each).
- ROM_LAT, 2: ROM read latency in clocks, legal range 1..4.

Ports:
- VGA_Clk, input, 1: the only clock. All state updates on the rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: when low, no new grants are issued. In-flight reads still complete.
- req, input, N_REQ: request bit per requester, held high until granted.
- addr, input, N_REQ*ADDR_W: requester i's address is in bits [i*ADDR_W +: ADDR_W]. Must be stable while req[i] is high.
- gnt, output, N_REQ: one-hot grant, combinational, for the acceptance cycle only.
- rom_rd, output, 1: registered read strobe to the ROM.
- rom_addr, output, ADDR_W: registered ROM address.
- rom_data, input, DATA_W: ROM output, valid ROM_LAT clocks after the cycle in which rom_rd is high.
- rd_valid, output, N_REQ: one-hot return strobe.
- rd_data, output, DATA_W: returned word. It equals rom_data while any rd_valid bit is high, and 0 otherwise.
- busy, output, 1: high while any read is in flight (rom_rd or any tag stage valid).

## Operation
- Arbitration cycle:
  - Winner w = first i with req[i]=1, searching from ptr+1 upward modulo N_REQ.
  - gnt[w]=1 when enable=1, Reset=0 and some req is high. Otherwise gnt=0.
- On the edge that ends a grant cycle:
  - rom_rd<=1, rom_addr<=addr[w], ptr<=w.
  - Tag stage 0 <= {valid=1, idx=w}.
- With no grant on that edge, rom_rd<=0 and rom_addr holds its value.
- Tag pipeline:
  - ROM_LAT registered stages, shifting each clock.
  - The last stage drives rd_valid[idx] when valid.
- Requests may be withdrawn (req dropped) before a grant with no side effects.
- A requester may re-assert req in the cycle after its grant. Back-to-back grants to a single requester give one read per clock.
- An unused requester must tie req low. Its addr is ignored.
- Reset values:
  - gnt=0, rom_rd=0, rom_addr=0, rd_valid=0, rd_data=0, busy=0.
  - ptr=N_REQ-1, so requester 0 wins first.
  - All tag stages invalid.
- Reset mid-operation: all in-flight tags are discarded. No rd_valid is produced for reads issued before reset.
- enable falling while reads are in flight: pending returns still arrive. busy falls the clock after the last rd_valid.

## Timing
- Grant: same cycle as req (combinational from req, ptr, enable).
- rom_rd/rom_addr: high 1 clock after the grant cycle.
- rd_valid[w]: high exactly 1+ROM_LAT clocks after the grant cycle (3 with the default). It lasts one clock per grant.
- Returns come back in grant order. At most one rd_valid bit is high per clock.
- Throughput: one grant per clock whenever enable=1 and any req is high.
- Width rules:
  - ptr is ceil(log2(N_REQ)) bits and wraps from N_REQ-1 to 0.
  - Indices at or above N_REQ are never granted.

## Configuration
- SPRITE_ARB_ROUND_ROBIN_EN defined: round-robin as above. ptr updates on every grant.
- SPRITE_ARB_ROUND_ROBIN_EN undefined: fixed priority. The lowest index with req high always wins, and ptr is not implemented. Latency, handshake and reset behaviour are unchanged.

## Test plan
- Single requester: req[1]=1 with addr 0x0123 for 4 cycles, ROM returning addr as data. Required response:
  - gnt[1] high on 4 consecutive cycles.
  - rom_addr=0x0123 from cycle+1.
  - rd_valid[1] and rd_data=0x000123 on cycles +3..+6.
- All four requesting continuously, round-robin build. Grants must be 0,1,2,3,0,1… with one per clock. Returns are tagged identically, 3 clocks later.
- All four requesting continuously, macro undefined. Only requester 0 is granted. Dropping req[0] moves the grant to requester 1 in the same cycle.
- enable=0 after grants in cycles 0 and 1:
  - No gnt from cycle 2 on.
  - rd_valid still occurs in cycles 3 and 4.
  - busy goes low in cycle 5.
- Reset pulse 1 clock after two grants:
  - No rd_valid is produced for those grants.
  - All outputs are 0 during and after reset.
  - The next grant with all req high goes to requester 0.
- ROM_LAT=4, req[2] and req[3] simultaneous from reset. gnt[2] comes first, then gnt[3], and rd_valid follows each grant by 5 clocks.
